// File: rtl/dsp_mac_array_wb.sv
// N_CH signed multiply-accumulate channels behind a Wishbone classic slave, with
// wrap/saturate modes, sticky overflow interrupt and one accumulator mirrored on the IO pads.
module dsp_mac_array_wb #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int IO_W   = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_CYC,
  input  logic        wb_STB,
  input  logic        wb_WE,
  input  logic [3:0]  wb_SEL,
  input  logic [31:0] wb_ADR,
  input  logic [31:0] wb_DAT_MOSI,
  output logic [31:0] wb_DAT_MISO,
  output logic        wb_ACK,
  output logic [37:0] io_out,
  output logic [37:0] io_oeb,
  output logic        user_irq
);
  localparam int P_W = 2 * DATA_W;
  localparam int S_W = ACC_W + 1;
  localparam logic [37:0] OEB_MASK = ~((38'(1) << IO_W) - 38'(1));

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  lanes);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = lanes[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    return res;
  endfunction

  logic       req, wr_req, w1c;
  logic [8:0] adr;
  logic [3:0] ch_idx;
  logic [1:0] reg_idx;
  logic       ch_valid, status_hit, ien_hit, iosel_hit;
  logic       unused_adr;

  // The request is taken only while ACK is low, so ACK can never stay high two cycles.
  assign req        = wb_CYC & wb_STB & ~wb_ACK;
  assign wr_req     = req & wb_WE;
  assign adr        = wb_ADR[8:0];
  assign ch_idx     = adr[7:4];
  assign reg_idx    = adr[3:2];
  assign ch_valid   = ~adr[8] && (int'(ch_idx) < N_CH);
  assign status_hit = adr[8] && (adr[7:2] == 6'd0);
  assign ien_hit    = adr[8] && (adr[7:2] == 6'd1);
  assign iosel_hit  = adr[8] && (adr[7:2] == 6'd2);
  assign w1c        = wr_req & status_hit;
  assign unused_adr = ^{wb_ADR[31:9], wb_ADR[1:0]};

  logic [N_CH-1:0]             busy, ovf;
  logic [N_CH-1:0][ACC_W-1:0]  acc_bus;
  logic [N_CH-1:0][31:0]       rd_bus;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [DATA_W-1:0]     a_q, b_q, b_nx;
    logic                  sat_q, mul_only_q, v1_q, ovf_q;
    logic signed [P_W-1:0] p1_q, prod;
    logic [ACC_W-1:0]      acc_q, acc_nx;
    logic signed [S_W-1:0] sum;
    logic                  hit, wr_a, wr_b, wr_ctrl, clr, sum_ovf;
    logic [31:0]           a_m, b_m, rd;
    logic                  unused_hi;

    assign hit     = ch_valid && (ch_idx == 4'(c));
    assign wr_a    = wr_req & hit & (reg_idx == 2'd0);
    assign wr_b    = wr_req & hit & (reg_idx == 2'd1);
    assign wr_ctrl = wr_req & hit & (reg_idx == 2'd2);
    assign clr     = wr_ctrl & wb_SEL[0] & wb_DAT_MOSI[1];

    assign a_m       = merge_bytes(32'(a_q), wb_DAT_MOSI, wb_SEL);
    assign b_m       = merge_bytes(32'(b_q), wb_DAT_MOSI, wb_SEL);
    assign b_nx      = b_m[DATA_W-1:0];
    assign unused_hi = ^{a_m, b_m};

    // The launch multiplies by the B value being written on this very edge.
    assign prod    = P_W'($signed(a_q)) * P_W'($signed(b_nx));
    assign sum     = S_W'($signed(acc_q)) + S_W'(p1_q);
    assign sum_ovf = sum[S_W-1] ^ sum[S_W-2];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
      acc_nx = sum[ACC_W-1:0];
      if (mul_only_q)
        acc_nx = ACC_W'(p1_q);
      else if (sum_ovf && sat_q)
        acc_nx = sum[S_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end

    always_comb begin
      rd = '0;
      if (hit) begin
        case (reg_idx)
          2'd0:    rd = 32'(a_q);
          2'd1:    rd = 32'(b_q);
          2'd2:    rd = {29'd0, mul_only_q, 1'b0, sat_q};
          default: rd = 32'($signed(acc_q));
        endcase
      end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
        a_q        <= '0;
        b_q        <= '0;
        sat_q      <= 1'b0;
        mul_only_q <= 1'b0;
        p1_q       <= '0;
        v1_q       <= 1'b0;
        acc_q      <= '0;
        ovf_q      <= 1'b0;
      end else begin
        if (wr_a) a_q <= a_m[DATA_W-1:0];
        if (wr_b) b_q <= b_nx;
        if (wr_ctrl && wb_SEL[0]) begin
          sat_q      <= wb_DAT_MOSI[0];
          mul_only_q <= wb_DAT_MOSI[2];
        end
        v1_q <= wr_b;
        if (wr_b) p1_q <= prod;
        // A clear drops any product still in flight.
        if (clr)
          acc_q <= '0;
        else if (v1_q)
          acc_q <= acc_nx;
        if (v1_q && !clr && !mul_only_q && sum_ovf)
          ovf_q <= 1'b1;
        else if (w1c && wb_DAT_MOSI[8+c])
          ovf_q <= 1'b0;
      end
    end

    assign busy[c]    = v1_q;
    assign ovf[c]     = ovf_q;
    assign acc_bus[c] = acc_q;
    assign rd_bus[c]  = rd;
  end

  logic [N_CH-1:0] ien_q;
  logic [2:0]      iosel_q;
  logic [31:0]     rdata;
  logic [37:0]     io_nx;

  always_comb begin
    rdata = '0;
    for (int c = 0; c < N_CH; c++) rdata = rdata | rd_bus[c];
    if (status_hit) begin
      rdata[N_CH-1:0]  = busy;
      rdata[N_CH+7:8]  = ovf;
    end else if (ien_hit) begin
      rdata[N_CH-1:0]  = ien_q;
    end else if (iosel_hit) begin
      rdata[2:0]       = iosel_q;
    end
  end

  always_comb begin
    io_nx = '0;
    for (int c = 0; c < N_CH; c++)
      if (iosel_q == 3'(c)) io_nx[IO_W-1:0] = acc_bus[c][ACC_W-1 -: IO_W];
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ACK      <= 1'b0;
      wb_DAT_MISO <= '0;
      ien_q       <= '0;
      iosel_q     <= '0;
      io_out      <= '0;
      user_irq    <= 1'b0;
    end else begin
      wb_ACK      <= req;
      wb_DAT_MISO <= (req && !wb_WE) ? rdata : '0;
      if (wr_req && ien_hit && wb_SEL[0])   ien_q   <= wb_DAT_MOSI[N_CH-1:0];
      if (wr_req && iosel_hit && wb_SEL[0]) iosel_q <= wb_DAT_MOSI[2:0];
      io_out      <= io_nx;
      user_irq    <= |(ovf & ien_q);
    end
  end

  assign io_oeb = OEB_MASK;

endmodule
